// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared CPU constants and small helpers.
//   XLEN             data/address width (32)
//   DEFAULT_RESET_PC PC loaded on reset
//   DEFAULT_PC_STEP  sequential fetch increment in bytes
//   NOP_INSN         canonical NOP encoding
//   rb_state_e       states of the pending-redirect buffer
//   align_pc()       forces a target address onto a word boundary
// ---------------------------------------------------------------------------
package cpu_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int              DEFAULT_PC_STEP  = 4;
    localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0000;

    typedef enum logic {
        RB_IDLE = 1'b0,
        RB_PEND = 1'b1
    } rb_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_redirect_buf.sv
// ---------------------------------------------------------------------------
// fetch_redirect_buf: one-entry buffer that remembers a redirect which
// arrived while fetch was paused, so it can be applied once pause drops.
// Ports:
//   clk, rst          clock, async active-high reset
//   pause             fetch stall
//   redirect          taken branch / jump request
//   redirect_pc       redirect target (aligned here before storing)
//   pend_valid        a redirect is buffered (also the FSM state: 1 = PEND)
//   pend_pc           buffered, aligned target
// ---------------------------------------------------------------------------
module fetch_redirect_buf
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            pend_valid,
    output logic [XLEN-1:0] pend_pc
);
    rb_state_e       r_state;
    logic [XLEN-1:0] r_pend_pc;
    rb_state_e       w_state_nxt;
    logic [XLEN-1:0] w_pend_pc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RB_IDLE;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_pc_nxt = r_pend_pc;
        case (r_state)
            RB_IDLE: begin
                if (pause && redirect) begin
                    w_state_nxt   = RB_PEND;
                    w_pend_pc_nxt = align_pc(redirect_pc);
                end
            end
            RB_PEND: begin
                if (pause) begin
                    // Newest redirect wins while still stalled.
                    if (redirect) w_pend_pc_nxt = align_pc(redirect_pc);
                end else begin
                    // The top consumes the entry on this edge.
                    w_state_nxt = RB_IDLE;
                end
            end
            default: w_state_nxt = RB_IDLE;
        endcase
    end

    assign pend_valid = (r_state == RB_PEND);
    assign pend_pc    = r_pend_pc;
endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch: instruction-fetch stage. Holds the PC, presents it to a
// combinational instruction memory and forwards pc+PC_STEP and the fetched
// word to the IF/ID register. Redirects arriving under pause are held in
// fetch_redirect_buf and applied when pause drops.
// Ports:
//   clk, rst      clock, async active-high reset
//   pause         hazard-unit stall (also stalls IF/ID)
//   redirect      taken branch / jump; redirect_pc is its target
//   imem_addr     instruction memory address (= pc)
//   imem_rdata    combinational instruction memory data
//   p_out, i_out  pc+PC_STEP and fetched instruction for IF/ID
//   flush         clears IF/ID; never asserted under pause or reset
//   pc            current fetch PC
//   fetch_cnt     fetch counter, only when FETCH_PERF_CNT_EN is defined
// Handshake: no valid/ready; pause is a level stall sampled every edge.
// ---------------------------------------------------------------------------
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] p_out,
    output logic [XLEN-1:0] i_out,
    output logic            flush,
    output logic [XLEN-1:0] pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt
`endif
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_seq;
    logic            w_pend_valid;
    logic [XLEN-1:0] w_pend_pc;

    fetch_redirect_buf u_rbuf (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pend_valid  (w_pend_valid),
        .pend_pc     (w_pend_pc)
    );

    // Wraps modulo 2^32 naturally.
    assign w_pc_seq = r_pc + XLEN'(PC_STEP);

    always_comb begin
        w_pc_nxt = r_pc;
        if (!pause) begin
            // A live redirect beats a buffered one: it is newer.
            if (redirect)          w_pc_nxt = align_pc(redirect_pc);
            else if (w_pend_valid) w_pc_nxt = w_pend_pc;
            else                   w_pc_nxt = w_pc_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_nxt;
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign p_out     = w_pc_seq;
    assign i_out     = imem_rdata;
    // Gated by rst so a redirect seen during reset cannot clear IF/ID.
    assign flush     = (redirect | w_pend_valid) & ~pause & ~rst;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (!pause && !flush && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, sets the sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pause  input  1  stall from the hazard unit; the same signal drives the IF/ID register pause.
REQ-006 redirect  input  1  taken branch or jump request.
REQ-007 redirect_pc  input  32  target address for redirect.
REQ-008 imem_addr  output  32  instruction memory address, equal to pc.
REQ-009 imem_rdata  input  32  combinational instruction memory read data.
REQ-010 p_out  output  32  pc+PC_STEP, drives IF/ID p_in.
REQ-011 i_out  output  32  fetched instruction, drives IF/ID i_in.
REQ-012 flush  output  1  clears IF/ID (wired to its rst).
REQ-013 pc  output  32  current fetch PC.

Function
REQ-014 imem_addr, p_out and i_out SHALL be combinational from pc and imem_rdata, with zero-cycle fetch latency; p_out wraps modulo 2^32.
REQ-015 State SHALL be pc plus a one-entry pending-redirect buffer (pend_valid, pend_pc), giving two states: IDLE (pend_valid=0) and PEND (pend_valid=1).
REQ-016 IDLE, pause=0, redirect=1: pc <= {redirect_pc[31:2],2'b00}; state stays IDLE.
REQ-017 IDLE, pause=0, redirect=0: pc <= pc+PC_STEP.
REQ-018 IDLE, pause=1, redirect=1: pc holds; pend_pc <= aligned redirect_pc; go to PEND.
REQ-019 IDLE, pause=1, redirect=0: pc holds.
REQ-020 PEND, pause=1: pc holds; a new redirect overwrites pend_pc, and the newest redirect wins.
REQ-021 PEND, pause=0: pc <= aligned redirect_pc if redirect=1, else pc <= pend_pc; go to IDLE.
REQ-022 flush SHALL be combinational: (redirect | pend_valid) & ~pause; flush is never asserted while pause=1, so a stalled IF/ID entry is preserved.
REQ-023 PC wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000 with no error indication.

Reset
REQ-024 rst=1 SHALL immediately set pc=RESET_PC, pend_valid=0, pend_pc=0, and the counter (if present)=0, regardless of clk.
REQ-025 During reset, flush=0, imem_addr=RESET_PC and p_out=RESET_PC+PC_STEP.
REQ-026 A redirect pending when reset asserts SHALL be discarded.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN defined: output fetch_cnt (32 bits) increments on each clk edge with pause=0 and flush=0, and saturates at 32'hFFFF_FFFF.
REQ-028 Macro FETCH_PERF_CNT_EN undefined: the fetch_cnt port and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-029 Shared package cpu_pkg SHALL hold XLEN=32, the default RESET_PC, PC_STEP and the NOP encoding 32'h0000_0000.
REQ-030 The pending-redirect buffer SHALL be a sub-module named fetch_redirect_buf (inputs: pause, redirect, redirect_pc; outputs: pend_valid, pend_pc).

Verification
REQ-031 Reset release, pause=0, 4 cycles -> pc sequence 0,4,8,12; p_out=pc+4; flush=0 throughout.
REQ-032 pc=0x10, redirect=1, redirect_pc=0x103 -> flush=1 that cycle; next pc=0x100.
REQ-033 pc=0x20, pause=1 with redirect=1 to 0x200 for 1 cycle, pause held 3 cycles -> pc stays 0x20, flush=0 during pause; the cycle pause drops, flush=1; next pc=0x200.
REQ-034 PEND with pend_pc=0x200, a second redirect to 0x300 while still paused -> after pause drops, pc=0x300.
REQ-035 pc=0xFFFF_FFFC, no pause -> next pc=0x0000_0000.
REQ-036 Assert rst asynchronously mid-cycle while in PEND -> pc=RESET_PC immediately; no redirect is applied after release; fetch_cnt=0 (with FETCH_PERF_CNT_EN defined).
